// File: rtl/mem_stage_if.sv
// Byte-wide data-memory port between mem_stage (master) and the memory arbiter (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_busy;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    modport master (
        output mem_req, mem_a, mem_dout, mem_wr,
        input  mem_busy, mem_din
    );

    modport slave (
        input  mem_req, mem_a, mem_dout, mem_wr,
        output mem_busy, mem_din
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: serialises LOAD/STORE onto a byte-wide bus, little-endian.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned half/word accesses with a misalign_o pulse.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_addr_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    mem_stage_if.master mem,
    output logic        stall_req_o,
    output logic        misalign_o
);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          state, state_next;
    logic [1:0]      k, k_next;
    logic [2:0][7:0] byte_buf;
    logic            capture;
    logic            drive;
    logic [1:0]      drive_idx;
    logic [7:0]      store_byte;
    logic [31:0]     raw_word, load_value;

    logic [2:0] funct3;
    logic       is_load, is_store, is_mem, fmt_ok, misaligned;
    logic [1:0] last_idx;

    // funct7 bit 5 has no meaning for loads and stores.
    logic unused_funct7;
    assign unused_funct7 = opcode_i[10];

    assign funct3   = opcode_i[9:7];
    assign is_load  = (opcode_i[6:0] == OP_LOAD);
    assign is_store = (opcode_i[6:0] == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign fmt_ok   = (is_load  && (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) ||
                      (is_store && (funct3 inside {3'b000, 3'b001, 3'b010}));
    assign last_idx = (funct3[1:0] == 2'b00) ? 2'd0 :
                      (funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = fmt_ok &&
                        ((funct3[1:0] == 2'b01 && mem_addr_i[0]) ||
                         (funct3[1:0] == 2'b10 && mem_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            state    <= IDLE;
            k        <= 2'd0;
            // NOTE: the byte buffer is explicitly cleared so an aborted load leaves nothing stale.
            byte_buf <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
            if (capture) begin
                case (k)
                    2'd1:    byte_buf[0] <= mem.mem_din;
                    2'd2:    byte_buf[1] <= mem.mem_din;
                    2'd3:    byte_buf[2] <= mem.mem_din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        state_next  = state;
        k_next      = k;
        capture     = 1'b0;
        drive       = 1'b0;
        drive_idx   = 2'd0;
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        misalign_o  = 1'b0;

        case (state)
            IDLE: begin
                // rst acts at the edge; while it is high in IDLE nothing is passed or started.
                if (rst) begin
                    wd_o    = '0;
                    wreg_o  = 1'b0;
                    wdata_o = '0;
                end else if (is_mem) begin
                    wreg_o  = 1'b0;
                    wdata_o = '0;
                    if (!fmt_ok || misaligned) begin
                        misalign_o = misaligned;
                    end else if (mem.mem_busy) begin
                        stall_req_o = 1'b1;
                    end else begin
                        stall_req_o = 1'b1;
                        drive       = 1'b1;
                        k_next      = 2'd1;
                        state_next  = (last_idx == 2'd0) ? DONE : XFER;
                    end
                end
            end
            XFER: begin
                wreg_o      = 1'b0;
                wdata_o     = '0;
                stall_req_o = 1'b1;
                drive       = 1'b1;
                drive_idx   = k;
                capture     = is_load;
                k_next      = k + 2'd1;
                if (k == last_idx) state_next = DONE;
            end
            DONE: begin
                // The last load byte arrives on mem_din this cycle and is used directly.
                if (is_store) begin
                    wreg_o  = 1'b0;
                    wdata_o = '0;
                end else if (is_load) begin
                    wdata_o = load_value;
                end
                state_next = IDLE;
                k_next     = 2'd0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (last_idx)
            2'd0:    raw_word = {24'h0, mem.mem_din};
            2'd1:    raw_word = {16'h0, mem.mem_din, byte_buf[0]};
            default: raw_word = {mem.mem_din, byte_buf[2], byte_buf[1], byte_buf[0]};
        endcase
        case (funct3)
            3'b000:  load_value = {{24{raw_word[7]}}, raw_word[7:0]};
            3'b001:  load_value = {{16{raw_word[15]}}, raw_word[15:0]};
            3'b100:  load_value = {24'h0, raw_word[7:0]};
            3'b101:  load_value = {16'h0, raw_word[15:0]};
            default: load_value = raw_word;
        endcase
    end

    always_comb begin
        case (drive_idx)
            2'd0:    store_byte = wdata_i[7:0];
            2'd1:    store_byte = wdata_i[15:8];
            2'd2:    store_byte = wdata_i[23:16];
            default: store_byte = wdata_i[31:24];
        endcase
    end

    assign mem.mem_req  = drive;
    assign mem.mem_wr   = drive & is_store;
    assign mem.mem_a    = drive ? (mem_addr_i + {30'd0, drive_idx}) : 32'd0;
    assign mem.mem_dout = (drive & is_store) ? store_byte : 8'd0;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table plus multi-cycle access sequences.
module tb_mem_stage;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        misalign_o;

  mem_stage_if bus();

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .opcode_i   (opcode_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .mem_addr_i (mem_addr_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .mem        (bus),
    .stall_req_o(stall_req_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Byte memory with one-cycle read latency; logs every bus cycle.
  logic [7:0]  mem_model [logic [31:0]];
  logic [31:0] rd_q[$];
  logic [39:0] wr_q[$];
  bit          mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      mem_model[32'h100] = 8'h78; mem_model[32'h101] = 8'h56;
      mem_model[32'h102] = 8'h34; mem_model[32'h103] = 8'h12;
      mem_model[32'h200] = 8'h80;
      mem_model[32'h202] = 8'h34; mem_model[32'h203] = 8'h92;
      mem_init = 1'b1;
    end
    if (bus.mem_req && bus.mem_wr) begin
      mem_model[bus.mem_a] = bus.mem_dout;
      wr_q.push_back({bus.mem_a, bus.mem_dout});
    end
    if (bus.mem_req && !bus.mem_wr) rd_q.push_back(bus.mem_a);
    bus.mem_din <= mem_model.exists(bus.mem_a) ? mem_model[bus.mem_a] : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] mk_op(input logic [2:0] f3, input logic [6:0] op7);
    return {1'b0, f3, op7};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [10:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] wdata, input logic [31:0] addr);
    opcode_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; mem_addr_i = addr;
  endtask

  task automatic set_nop();
    set_in(mk_op(3'b000, OP_IMM), 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // Holds one instruction in ex_mem until stall_req_o drops, then reports the final cycle.
  task automatic run_access(input string tag, input logic [10:0] op, input logic [4:0] wd,
                            input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                            output int stalls, output logic [31:0] r_wdata, output logic r_wreg,
                            output logic [4:0] r_wd, output logic r_mis);
    set_in(op, wd, wreg, wdata, addr);
    #1;
    stalls = 0;
    while (stall_req_o && stalls < 20) begin
      stalls++;
      tick();
      #1;
    end
    check({tag, "_bounded"}, 32'(stalls < 20), 32'd1);
    check({tag, "_final_req"}, 32'(bus.mem_req), 32'd0);
    r_wdata = wdata_o; r_wreg = wreg_o; r_wd = wd_o; r_mis = misalign_o;
    tick();
    set_nop();
  endtask

  task automatic check_rd(input string tag, input logic [31:0] base, input int n);
    check({tag, "_rd_count"}, 32'(rd_q.size()), 32'(n));
    for (int j = 0; j < n; j++)
      check($sformatf("%s_rd%0d", tag, j), (j < rd_q.size()) ? rd_q[j] : 32'hDEAD_DEAD, base + 32'(j));
  endtask

  task automatic check_wr(input string tag, input logic [31:0] base, input logic [31:0] data, input int n);
    logic [31:0] sh;
    check({tag, "_wr_count"}, 32'(wr_q.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      sh = data >> (8 * j);
      check($sformatf("%s_wr%0d_addr", tag, j), (j < wr_q.size()) ? wr_q[j][39:8] : 32'hDEAD_DEAD, base + 32'(j));
      check($sformatf("%s_wr%0d_data", tag, j), (j < wr_q.size()) ? 32'(wr_q[j][7:0]) : 32'hDEAD_DEAD, 32'(sh[7:0]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wd"}, 32'(wd_o), 32'd0);
    check({tag, "_wreg"}, 32'(wreg_o), 32'd0);
    check({tag, "_wdata"}, wdata_o, 32'd0);
    check({tag, "_req"}, 32'(bus.mem_req), 32'd0);
    check({tag, "_wr"}, 32'(bus.mem_wr), 32'd0);
    check({tag, "_a"}, bus.mem_a, 32'd0);
    check({tag, "_dout"}, 32'(bus.mem_dout), 32'd0);
    check({tag, "_stall"}, 32'(stall_req_o), 32'd0);
    check({tag, "_misalign"}, 32'(misalign_o), 32'd0);
  endtask

  typedef struct {
    logic [10:0] op;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        busy;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_stall;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=%0t", $time, 200000);
    $fatal(1);
  end

  initial begin
    vec_t        vecs[11];
    int          stalls;
    logic [31:0] r_wdata;
    logic        r_wreg, r_mis;
    logic [4:0]  r_wd;

    // Single-cycle behaviour in IDLE; none of these rows starts a bus access.
    vecs[0]  = '{{1'b1, 3'b000, OP_ALU}, 5'd5,  1'b1, 32'hDEADBEEF, 32'h1234,     1'b0, 5'd5,  1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{mk_op(3'b000, OP_IMM),  5'd31, 1'b0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b0, 32'h00000001, 1'b0};
    vecs[2]  = '{mk_op(3'b011, OP_LOAD), 5'd3,  1'b1, 32'h00000055, 32'h100,      1'b0, 5'd3,  1'b0, 32'h0,        1'b0};
    vecs[3]  = '{mk_op(3'b110, OP_LOAD), 5'd3,  1'b1, 32'h00000055, 32'h100,      1'b0, 5'd3,  1'b0, 32'h0,        1'b0};
    vecs[4]  = '{mk_op(3'b111, OP_LOAD), 5'd8,  1'b1, 32'h00000055, 32'h104,      1'b1, 5'd8,  1'b0, 32'h0,        1'b0};
    vecs[5]  = '{mk_op(3'b011, OP_STORE),5'd1,  1'b1, 32'h12345678, 32'h300,      1'b0, 5'd1,  1'b0, 32'h0,        1'b0};
    vecs[6]  = '{mk_op(3'b100, OP_STORE),5'd1,  1'b0, 32'h12345678, 32'h300,      1'b0, 5'd1,  1'b0, 32'h0,        1'b0};
    vecs[7]  = '{mk_op(3'b111, OP_STORE),5'd2,  1'b1, 32'hFFFFFFFF, 32'h301,      1'b1, 5'd2,  1'b0, 32'h0,        1'b0};
    vecs[8]  = '{mk_op(3'b010, OP_LOAD), 5'd9,  1'b1, 32'h00000077, 32'h100,      1'b1, 5'd9,  1'b0, 32'h0,        1'b1};
    vecs[9]  = '{mk_op(3'b000, OP_STORE),5'd0,  1'b0, 32'h000000FF, 32'h310,      1'b1, 5'd0,  1'b0, 32'h0,        1'b1};
    vecs[10] = '{mk_op(3'b101, OP_LOAD), 5'd4,  1'b1, 32'h00000000, 32'h202,      1'b1, 5'd4,  1'b0, 32'h0,        1'b1};

    // Reset: a LW is presented while rst is high; everything stays quiet.
    rst = 1'b1;
    bus.mem_busy = 1'b0;
    set_in(mk_op(3'b010, OP_LOAD), 5'd7, 1'b1, 32'hCAFEF00D, 32'h100);
    tick();
    tick();
    #1;
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    set_nop();
    tick();

    for (int i = 0; i < 11; i++) begin
      set_in(vecs[i].op, vecs[i].wd, vecs[i].wreg, vecs[i].wdata, vecs[i].addr);
      bus.mem_busy = vecs[i].busy;
      #1;
      check($sformatf("v%0d_wd", i), 32'(wd_o), 32'(vecs[i].e_wd));
      check($sformatf("v%0d_wreg", i), 32'(wreg_o), 32'(vecs[i].e_wreg));
      check($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wdata);
      check($sformatf("v%0d_stall", i), 32'(stall_req_o), 32'(vecs[i].e_stall));
      check($sformatf("v%0d_req", i), 32'(bus.mem_req), 32'd0);
      check($sformatf("v%0d_wr", i), 32'(bus.mem_wr), 32'd0);
      check($sformatf("v%0d_a", i), bus.mem_a, 32'd0);
      check($sformatf("v%0d_dout", i), 32'(bus.mem_dout), 32'd0);
      check($sformatf("v%0d_misalign", i), 32'(misalign_o), 32'd0);
      tick();
    end
    set_nop();
    bus.mem_busy = 1'b0;
    tick();

    // LW 0x100: four consecutive byte addresses, stall for exactly four cycles.
    rd_q.delete(); wr_q.delete();
    run_access("lw", mk_op(3'b010, OP_LOAD), 5'd7, 1'b1, 32'h0, 32'h100, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lw_stalls", 32'(stalls), 32'd4);
    check("lw_wdata", r_wdata, 32'h12345678);
    check("lw_wreg", 32'(r_wreg), 32'd1);
    check("lw_wd", 32'(r_wd), 32'd7);
    check_rd("lw", 32'h100, 4);
    check("lw_no_writes", 32'(wr_q.size()), 32'd0);

    // Byte and half loads, signed and unsigned.
    rd_q.delete();
    run_access("lb", mk_op(3'b000, OP_LOAD), 5'd10, 1'b1, 32'h0, 32'h200, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lb_stalls", 32'(stalls), 32'd1);
    check("lb_wdata", r_wdata, 32'hFFFFFF80);
    check_rd("lb", 32'h200, 1);
    run_access("lbu", mk_op(3'b100, OP_LOAD), 5'd10, 1'b1, 32'h0, 32'h200, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lbu_wdata", r_wdata, 32'h00000080);
    rd_q.delete();
    run_access("lh", mk_op(3'b001, OP_LOAD), 5'd11, 1'b1, 32'h0, 32'h202, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lh_stalls", 32'(stalls), 32'd2);
    check("lh_wdata", r_wdata, 32'hFFFF9234);
    check_rd("lh", 32'h202, 2);
    run_access("lhu", mk_op(3'b101, OP_LOAD), 5'd11, 1'b1, 32'h0, 32'h202, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lhu_wdata", r_wdata, 32'h00009234);

    // Stores: SH writes two bytes, SB one; no writeback.
    rd_q.delete(); wr_q.delete();
    run_access("sh", mk_op(3'b001, OP_STORE), 5'd4, 1'b1, 32'hAABBCCDD, 32'h300, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("sh_stalls", 32'(stalls), 32'd2);
    check("sh_wreg", 32'(r_wreg), 32'd0);
    check("sh_wdata", r_wdata, 32'd0);
    check_wr("sh", 32'h300, 32'hAABBCCDD, 2);
    check("sh_no_reads", 32'(rd_q.size()), 32'd0);
    wr_q.delete();
    run_access("sb", mk_op(3'b000, OP_STORE), 5'd4, 1'b1, 32'h000000A5, 32'h310, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("sb_stalls", 32'(stalls), 32'd1);
    check_wr("sb", 32'h310, 32'h000000A5, 1);

    // LW held off by mem_busy for three cycles, then the normal access.
    rd_q.delete(); wr_q.delete();
    bus.mem_busy = 1'b1;
    set_in(mk_op(3'b010, OP_LOAD), 5'd2, 1'b1, 32'h0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("busy%0d_req", i), 32'(bus.mem_req), 32'd0);
      check($sformatf("busy%0d_stall", i), 32'(stall_req_o), 32'd1);
      tick();
    end
    bus.mem_busy = 1'b0;
    run_access("busy_lw", mk_op(3'b010, OP_LOAD), 5'd2, 1'b1, 32'h0, 32'h100, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("busy_lw_stalls", 32'(stalls), 32'd4);
    check("busy_lw_wdata", r_wdata, 32'h12345678);
    check_rd("busy_lw", 32'h100, 4);

    // Word access straddling the top of the address space.
    rd_q.delete(); wr_q.delete();
    run_access("sw_wrap", mk_op(3'b010, OP_STORE), 5'd1, 1'b1, 32'h0A0B0C0D, 32'hFFFFFFFE, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("sw_wrap_wreg", 32'(r_wreg), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check("sw_wrap_stalls", 32'(stalls), 32'd0);
    check("sw_wrap_misalign", 32'(r_mis), 32'd1);
    check("sw_wrap_no_writes", 32'(wr_q.size()), 32'd0);
    #1;
    check("sw_wrap_misalign_pulse_end", 32'(misalign_o), 32'd0);
    run_access("lw_wrap", mk_op(3'b010, OP_LOAD), 5'd1, 1'b1, 32'h0, 32'hFFFFFFFE, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lw_wrap_misalign", 32'(r_mis), 32'd1);
    check("lw_wrap_wreg", 32'(r_wreg), 32'd0);
    check("lw_wrap_no_reads", 32'(rd_q.size()), 32'd0);
`else
    check("sw_wrap_stalls", 32'(stalls), 32'd4);
    check("sw_wrap_misalign", 32'(r_mis), 32'd0);
    check_wr("sw_wrap", 32'hFFFFFFFE, 32'h0A0B0C0D, 4);
    run_access("lw_wrap", mk_op(3'b010, OP_LOAD), 5'd1, 1'b1, 32'h0, 32'hFFFFFFFE, stalls, r_wdata, r_wreg, r_wd, r_mis);
    check("lw_wrap_wdata", r_wdata, 32'h0A0B0C0D);
    check_rd("lw_wrap", 32'hFFFFFFFE, 4);
`endif

    // rst raised in the second cycle of a SW: two bytes land, then silence.
    rd_q.delete(); wr_q.delete();
    set_in(mk_op(3'b010, OP_STORE), 5'd6, 1'b1, 32'h11223344, 32'h400);
    #1;
    check("rst_sw_c1_a", bus.mem_a, 32'h400);
    tick();
    rst = 1'b1;
    #1;
    check("rst_sw_c2_a", bus.mem_a, 32'h401);
    tick();
    #1;
    check_all_zero("rst_sw_after");
    tick();
    rst = 1'b0;
    set_nop();
    for (int i = 0; i < 4; i++) tick();
    check_wr("rst_sw", 32'h400, 32'h11223344, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
